// File: rtl/pingpang_buffer.sv
// pingpang_buffer: two-bank ping-pong stream buffer with valid/ready on both sides
// and early bank closure via in_last. Define PINGPANG_STATUS_EN for bank_full/swap_cnt.
module pingpang_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
`ifdef PINGPANG_STATUS_EN
    ,
    output logic [1:0]        bank_full,
    output logic [15:0]       swap_cnt
`endif
);

    logic              wr_bank_r;
    logic              rd_bank_r;
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [1:0]        full_r;
    logic [AW:0]       len_r [2];
    logic [DATA_W-1:0] mem_r [2][DEPTH];
    logic              out_valid_r;
    logic [DATA_W-1:0] out_data_r;
    logic              out_last_r;

    logic              wr_fire_s;
    logic              wr_close_s;
    logic              fetch_s;
    logic              rd_last_s;
    logic              rd_free_s;
    logic [1:0]        full_set_s;
    logic [1:0]        full_clr_s;

    assign wr_fire_s  = in_valid & ~full_r[wr_bank_r];
    assign wr_close_s = wr_fire_s & (in_last | (wr_ptr_r == AW'(DEPTH - 1)));
    assign rd_last_s  = ({1'b0, rd_ptr_r} == (len_r[rd_bank_r] - (AW+1)'(1)));
    assign fetch_s    = full_r[rd_bank_r] & (~out_valid_r | out_ready);
    assign rd_free_s  = fetch_s & rd_last_s;

    // Writer sets only a non-full bank and reader clears only a full one, so both may apply at once.
    assign full_set_s = wr_close_s ? (wr_bank_r ? 2'b10 : 2'b01) : 2'b00;
    assign full_clr_s = rd_free_s  ? (rd_bank_r ? 2'b10 : 2'b01) : 2'b00;

    assign in_ready  = ~full_r[wr_bank_r];
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;

    // Bank storage; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            mem_r[wr_bank_r][wr_ptr_r] <= in_data;
        end
    end

    // Write side: pointer advance, bank closure and recorded frame length.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_bank_r <= 1'b0;
            wr_ptr_r  <= {AW{1'b0}};
            len_r[0]  <= {(AW+1){1'b0}};
            len_r[1]  <= {(AW+1){1'b0}};
        end else if (wr_fire_s) begin
            if (wr_close_s) begin
                len_r[wr_bank_r] <= {1'b0, wr_ptr_r} + (AW+1)'(1);
                wr_bank_r        <= ~wr_bank_r;
                wr_ptr_r         <= {AW{1'b0}};
            end else begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
        end else begin
            wr_ptr_r <= wr_ptr_r;
        end
    end

    // Per-bank full flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_r <= 2'b00;
        end else begin
            full_r <= (full_r | full_set_s) & ~full_clr_s;
        end
    end

    // Read side: prefetch into the output register whenever it is empty or being consumed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_bank_r   <= 1'b0;
            rd_ptr_r    <= {AW{1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_W{1'b0}};
            out_last_r  <= 1'b0;
        end else if (fetch_s) begin
            out_data_r  <= mem_r[rd_bank_r][rd_ptr_r];
            out_last_r  <= rd_last_s;
            out_valid_r <= 1'b1;
            if (rd_last_s) begin
                rd_bank_r <= ~rd_bank_r;
                rd_ptr_r  <= {AW{1'b0}};
            end else begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

`ifdef PINGPANG_STATUS_EN
    logic [15:0] swap_cnt_r;

    // Count of fully drained banks, wrapping at 16 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            swap_cnt_r <= 16'd0;
        end else if (rd_free_s) begin
            swap_cnt_r <= swap_cnt_r + 16'd1;
        end else begin
            swap_cnt_r <= swap_cnt_r;
        end
    end

    assign bank_full = full_r;
    assign swap_cnt  = swap_cnt_r;
`endif

endmodule

// File: tb/tb_pingpang_buffer.sv
// Self-checking bench for pingpang_buffer: a cycle vector table, directed corner
// sequences and a randomized run scored against a frame/word queue model.
module tb_pingpang_buffer;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
`ifdef PINGPANG_STATUS_EN
    logic [1:0]        bank_full;
    logic [15:0]       swap_cnt;
`endif

    int checks = 0;
    int failures = 0;

    pingpang_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
`ifdef PINGPANG_STATUS_EN
        , .bank_full(bank_full), .swap_cnt(swap_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       il;
        logic       ordy;
        logic       e_irdy;
        logic       e_ov;
        logic [7:0] e_od;
        logic       e_ol;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Leaves the bench at a falling edge with the DUT freshly out of reset.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] q[$];
        logic [8:0] exp_w;
        logic [8:0] prev_w;
        logic       prev_stall;
        logic       lastw;
        int wi, ri, pos, closed, delivered, got;
        logic started;

        // Short frame A1,A2,A3 with a stall, then a one-word frame in the other bank.
        tbl[0]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[2]  = '{1'b1, 8'hA3, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA1, 1'b0};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA1, 1'b0};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA2, 1'b0};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA3, 1'b1};
        tbl[8]  = '{1'b1, 8'hB1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA3, 1'b1};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA3, 1'b1};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'hB1, 1'b1};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hB1, 1'b1};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            in_valid = tbl[i].iv; in_data = tbl[i].id; in_last = tbl[i].il; out_ready = tbl[i].ordy;
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_irdy));
            check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            check($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(tbl[i].e_od));
            check($sformatf("vec%0d_out_last", i), 32'(out_last), 32'(tbl[i].e_ol));
            @(negedge clk);
        end

        // Fill both banks with the consumer stalled, then drain.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 2 * DEPTH; i++) begin
            in_valid = 1'b1; in_data = 8'(i); in_last = 1'b0;
            check("fill_in_ready", 32'(in_ready), 32'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("fill_in_ready_low", 32'(in_ready), 32'd0);
`ifdef PINGPANG_STATUS_EN
        check("fill_bank_full", 32'(bank_full), 32'h3);
`endif
        out_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 100 && got < 2 * DEPTH; cyc++) begin
            if (out_valid) begin
                check("drain_data", 32'(out_data), 32'(got));
                check("drain_last", 32'(out_last), 32'((got == DEPTH - 1) || (got == 2 * DEPTH - 1)));
                check("drain_in_ready", 32'(in_ready), 32'(got >= DEPTH - 1));
                got++;
            end
            @(negedge clk);
        end
        check("drain_count", 32'(got), 32'(2 * DEPTH));
        check("drain_out_valid_idle", 32'(out_valid), 32'd0);
`ifdef PINGPANG_STATUS_EN
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1; in_data = 8'(i); in_last = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (DEPTH + 4) @(negedge clk);
        check("swap_cnt_three", 32'(swap_cnt), 32'd3);
`endif

        // Streaming with both sides always ready; frame closed on word 99.
        do_reset();
        out_ready = 1'b1;
        wi = 0; ri = 0; started = 1'b0;
        for (int cyc = 0; cyc < 300 && ri < 100; cyc++) begin
            if (started) check("stream_no_gap", 32'(out_valid), 32'd1);
            if (out_valid) begin
                check("stream_data", 32'(out_data), 32'(ri));
                check("stream_last", 32'(out_last), 32'(((ri % DEPTH) == DEPTH - 1) || (ri == 99)));
                ri++;
                started = 1'b1;
            end
            if (wi < 100) begin
                in_valid = 1'b1; in_data = 8'(wi); in_last = (wi == 99);
                check("stream_in_ready", 32'(in_ready), 32'd1);
                if (in_ready) wi++;
            end else begin
                in_valid = 1'b0; in_last = 1'b0;
            end
            @(negedge clk);
        end
        check("stream_count", 32'(ri), 32'd100);
        in_valid = 1'b0;

        // Randomized traffic against a queue model of words and frame boundaries.
        do_reset();
        q.delete();
        wi = 0; pos = 0; closed = 0; delivered = 0;
        prev_stall = 1'b0; prev_w = '0;
        for (int cyc = 0; cyc < 3000 && (wi < 64 || q.size() > 0); cyc++) begin
            if (prev_stall) begin
                check("rand_hold_valid", 32'(out_valid), 32'd1);
                check("rand_hold_word", 32'({out_last, out_data}), 32'(prev_w));
            end
            if (closed - delivered == 0) check("rand_ready_idle", 32'(in_ready), 32'd1);
            if (!in_ready) check("rand_ready_low_two_frames", 32'(closed - delivered >= 2), 32'd1);
            out_ready = ($urandom_range(0, 2) != 0);
            if (out_valid && out_ready) begin
                check("rand_word_expected", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    exp_w = q.pop_front();
                    check("rand_word", 32'({out_last, out_data}), 32'(exp_w));
                end
                if (out_last) delivered++;
            end
            prev_stall = out_valid && !out_ready;
            prev_w = {out_last, out_data};
            if (wi < 64 && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_data = 8'($urandom);
                in_last = (wi == 63) || ($urandom_range(0, 7) == 0);
                if (in_ready) begin
                    lastw = in_last || (pos == DEPTH - 1);
                    q.push_back({lastw, in_data});
                    wi++;
                    if (lastw) begin
                        pos = 0;
                        closed++;
                    end else begin
                        pos++;
                    end
                end
            end else begin
                in_valid = 1'b0; in_last = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0;
        check("rand_all_written", 32'(wi), 32'd64);
        check("rand_queue_empty", 32'(q.size()), 32'd0);

        // Reset asserted mid-stream with a word already presented.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 10; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h30 + i); in_last = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("rst_pre_out_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rst_async_out_valid", 32'(out_valid), 32'd0);
        check("rst_async_out_data", 32'(out_data), 32'd0);
        check("rst_async_out_last", 32'(out_last), 32'd0);
        check("rst_async_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1; in_data = 8'h55; in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 10 && !out_valid; k++) @(negedge clk);
        check("rst_new_out_valid", 32'(out_valid), 32'd1);
        check("rst_new_out_data", 32'(out_data), 32'h55);
        check("rst_new_out_last", 32'(out_last), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_no_stale", 32'(out_valid), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
